// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencing controller: opcodes, states,
// instruction classes and the ALU / mux select codes it drives.
package mc_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned SRC_B_W  = 2;
  localparam int unsigned PC_SRC_W = 2;

  localparam logic [OP_W-1:0] OP_R_TYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J      = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ    = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI   = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI   = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI   = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI    = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI   = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI    = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW     = 6'h23;
  localparam logic [OP_W-1:0] OP_SW     = 6'h2B;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  typedef enum logic [2:0] {
    CLS_MEM     = 3'd0,
    CLS_R       = 3'd1,
    CLS_BEQ     = 3'd2,
    CLS_J       = 3'd3,
    CLS_IALU    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_t;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SLTI  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_RTYPE = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_LOGI  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 3'b110;

  localparam logic [SRC_B_W-1:0] SRCB_REG  = 2'b00;
  localparam logic [SRC_B_W-1:0] SRCB_FOUR = 2'b01;
  localparam logic [SRC_B_W-1:0] SRCB_IMM  = 2'b10;
  localparam logic [SRC_B_W-1:0] SRCB_BR   = 2'b11;

  localparam logic [PC_SRC_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [PC_SRC_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [PC_SRC_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/op_class_decode.sv
// Maps the instruction-register opcode to an instruction class, a store flag
// for the memory path, and the ALU operation used by I-type ALU instructions.
module op_class_decode
  import mc_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]     opcode,
  output op_class_t           op_class,
  output logic                is_store,
  output logic [ALU_OP_W-1:0] i_alu_op
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    is_store = 1'b0;
    i_alu_op = ALU_ADD;
    case (opcode)
      OP_LW:     op_class = CLS_MEM;
      OP_SW: begin
        op_class = CLS_MEM;
        is_store = 1'b1;
      end
      OP_R_TYPE: op_class = CLS_R;
      OP_BEQ:    op_class = CLS_BEQ;
      OP_J:      op_class = CLS_J;
      OP_ADDI: begin
        op_class = CLS_IALU;
        i_alu_op = ALU_ADD;
      end
      OP_SLTI: begin
        op_class = CLS_IALU;
        i_alu_op = ALU_SLTI;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        op_class = CLS_IALU;
        i_alu_op = ALU_LOGI;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller: steps each instruction through fetch,
// decode, execute, memory and write-back, driving datapath selects and enables.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_en,
  output logic [PC_SRC_W-1:0] pc_source,
  output logic                alu_src_a,
  output logic [SRC_B_W-1:0]  alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                retire,
  output logic                illegal_op,
  output logic [STATE_W-1:0]  state
);

  state_t              state_q;
  state_t              state_d;
  op_class_t           op_class;
  logic                is_store;
  logic [ALU_OP_W-1:0] i_alu_op;

  op_class_decode u_op_class_decode (
    .opcode   (opcode),
    .op_class (op_class),
    .is_store (is_store),
    .i_alu_op (i_alu_op)
  );

  // Outputs decode straight from the state register so an async reset
  // drops mem_req and every write enable in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_source  = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      // PC+4 is computed alongside the fetch; IR and PC load on completion.
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        alu_src_b = SRCB_BR;
        case (op_class)
          CLS_MEM:  state_d = S_MEM_ADDR;
          CLS_R:    state_d = S_R_EXEC;
          CLS_BEQ:  state_d = S_BRANCH;
          CLS_J:    state_d = S_JUMP;
          CLS_IALU: state_d = S_I_EXEC;
          default:  state_d = S_TRAP;
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = is_store ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      // The store retires only on the cycle memory accepts it.
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        retire  = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end

      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_RTYPE;
        state_d   = S_R_WB;
      end

      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_en     = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_en     = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = i_alu_op;
        state_d   = S_I_WB;
      end

      S_I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_TRAP: illegal_op = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

endmodule
